// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB memory slave: FSM state encoding, response
// codes, wait-counter width and the byte-offset helper used by address decode.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } apb_state_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Wait states are limited to 0..15, so four counter bits are enough.
  localparam int WAIT_CNT_W = 4;

  // Number of low address bits that select a byte inside one data word.
  function automatic int byte_off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_strb_ram.sv
// DEPTH x DATA_WIDTH storage for the APB slave, split into one 8-bit array per
// byte lane so each strobe bit gates its own lane. Write and read are both
// synchronous; the read data register has no reset (the slave masks it).
// A high clr zeroes every word at the next clock edge, so the slave reset must
// span at least one PCLK edge for the contents to be cleared.
module apb_strb_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_reg;

    // Lane write: clear has priority, otherwise write only when this strobe is set
    always_ff @(posedge clk) begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= 8'h00;
        end
      end else if (we && strb[gi]) begin
        mem[addr] <= wdata[gi*8 +: 8];
      end
    end

    // Registered lane read
    always_ff @(posedge clk) begin
      if (re) begin
        rd_reg <= mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = rd_reg;
  end

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 memory slave: byte-strobed writes, configurable wait
// states and a PSLVERR response for misaligned or out-of-range accesses.
// Optional macro APB_SLAVE_PROT_EN adds PPROT; the upper half of the word
// space then requires a privileged access (PPROT[0]=1).
//
// The access is performed at the edge that registers PREADY. The wait counter
// is examined one cycle ahead: with no wait states the access happens at the
// setup edge using the live bus values, otherwise at the edge ending the last
// wait cycle using the values captured at setup.
module apb_mem_slave
  import apb_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`ifdef APB_SLAVE_PROT_EN
  input  logic [2:0]              PPROT,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int OFF_BITS  = byte_off_bits(DATA_WIDTH);
  localparam int RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_L   = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = '0;

  apb_state_e                state_reg;
  logic [WAIT_CNT_W-1:0]     cnt_reg;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic                      write_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;
  logic [NUM_LANES-1:0]      strb_reg;
  logic                      pready_reg;
  logic                      pslverr_reg;
  logic                      rd_ok_reg;

  logic                      setup;
  logic                      from_cap;
  logic [ADDR_WIDTH-1:0]     acc_addr;
  logic                      acc_write;
  logic [DATA_WIDTH-1:0]     acc_wdata;
  logic [NUM_LANES-1:0]      acc_strb;
  logic [ADDR_WIDTH-1:0]     word_idx;
  logic                      misaligned;
  logic                      out_of_range;
  logic                      prot_err;
  logic                      acc_err;
  logic                      fire;
  logic                      ram_we;
  logic                      ram_re;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  // A setup phase is PSEL with PENABLE low; PENABLE high seen outside a
  // transfer is simply not a start condition.
  assign setup    = PSEL & ~PENABLE;

  // During ACCESS use the captured request, otherwise the live bus (the
  // zero-wait case performs the access at the setup edge itself).
  assign from_cap  = (state_reg == ST_ACCESS);
  assign acc_addr  = from_cap ? addr_reg  : PADDR;
  assign acc_write = from_cap ? write_reg : PWRITE;
  assign acc_wdata = from_cap ? wdata_reg : PWDATA;
  assign acc_strb  = from_cap ? strb_reg  : PSTRB;

  assign word_idx     = acc_addr >> OFF_BITS;
  assign misaligned   = |(acc_addr & OFF_MASK);
  assign out_of_range = ({1'b0, word_idx} >= DEPTH_L);

`ifdef APB_SLAVE_PROT_EN
  localparam logic [ADDR_WIDTH:0] HALF_L = (ADDR_WIDTH+1)'(DEPTH / 2);
  logic prot_reg;
  logic acc_priv;
  logic unused_pprot;

  assign acc_priv     = from_cap ? prot_reg : PPROT[0];
  assign prot_err     = ({1'b0, word_idx} >= HALF_L) & ~acc_priv;
  assign unused_pprot = &{1'b0, PPROT[2:1]};

  // Privilege bit is captured alongside the rest of the request
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prot_reg <= 1'b0;
    end else if (setup && state_reg != ST_ACCESS) begin
      prot_reg <= PPROT[0];
    end
  end
`else
  assign prot_err = 1'b0;
`endif

  assign acc_err = misaligned | out_of_range | prot_err;

  // The access fires at the edge that will raise PREADY; reset blocks it.
  assign fire = ~PRESET &
                ((setup & (state_reg != ST_ACCESS) & (WAIT_STATES == 0)) |
                 ((state_reg == ST_ACCESS) & PSEL & (cnt_reg == CNT_ONE)));

  assign ram_we = fire &  acc_write & ~acc_err;
  assign ram_re = fire & ~acc_write & ~acc_err;

  apb_strb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (RAM_AW)
  ) u_ram (
    .clk   (PCLK),
    .clr   (PRESET),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_idx[RAM_AW-1:0]),
    .wdata (acc_wdata),
    .strb  (acc_strb),
    .rdata (ram_rdata)
  );

  // Transfer FSM with wait counter, request capture and registered responses
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= CNT_ZERO;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= RESP_OKAY;
      rd_ok_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // Leaving the completion cycle always drops the response
          pready_reg  <= 1'b0;
          pslverr_reg <= RESP_OKAY;
          rd_ok_reg   <= 1'b0;
          state_reg   <= ST_IDLE;
          if (setup) begin
            addr_reg  <= PADDR;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
            strb_reg  <= PSTRB;
            cnt_reg   <= WAIT_L;
            if (WAIT_STATES == 0) begin
              pready_reg  <= 1'b1;
              pslverr_reg <= acc_err ? RESP_ERROR : RESP_OKAY;
              rd_ok_reg   <= ~acc_write & ~acc_err;
              state_reg   <= ST_DONE;
            end else begin
              state_reg   <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            cnt_reg   <= CNT_ZERO;
            state_reg <= ST_IDLE;
          end else if (cnt_reg == CNT_ONE) begin
            cnt_reg     <= CNT_ZERO;
            pready_reg  <= 1'b1;
            pslverr_reg <= acc_err ? RESP_ERROR : RESP_OKAY;
            rd_ok_reg   <= ~acc_write & ~acc_err;
            state_reg   <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  // Read data is only shown during the completion cycle of a good read.
  assign PRDATA  = rd_ok_reg ? ram_rdata : '0;

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave. It is the successor to the team's fixed 32-bit/16-word APB slave.
- Adds configurable data width, depth and wait states.
- Adds byte-lane write strobes and a PSLVERR error response.
- Sits behind the APB bridge as a scratch/config register bank.
- Samples all inputs on the rising edge of PCLK.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16, 32 or 64.
ADDR_WIDTH, 8, PADDR width in bytes.
DEPTH, 16, number of DATA_WIDTH words; must satisfy DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
WAIT_STATES, 0, extra access-phase cycles before PREADY; range 0..15.

Ports:
PCLK  input  1  APB clock; all logic on rising edge.
PRESET  input  1  asynchronous, active-high reset.
PADDR  input  ADDR_WIDTH  byte address.
PWRITE  input  1  1 = write, 0 = read.
PSEL  input  1  slave select.
PENABLE  input  1  access phase indicator.
PWDATA  input  DATA_WIDTH  write data.
PSTRB  input  DATA_WIDTH/8  byte-lane write strobes.
PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
PREADY  output  1  transfer completes in the cycle where PSEL=PENABLE=PREADY=1.
PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, asynchronous) forces:
  - state IDLE;
  - PREADY=0, PSLVERR=0, PRDATA=0;
  - wait counter 0;
  - every memory word 0.
- Reset asserted mid-transfer aborts the transfer; no write is committed.
- States: IDLE, ACCESS, DONE.
  - IDLE: on PSEL=1, PENABLE=0, capture PADDR, PWRITE, PWDATA and PSTRB, load the counter with WAIT_STATES, then go to ACCESS. Other inputs stay in IDLE.
  - ACCESS: while the counter is nonzero, decrement it and hold PREADY=0. When the counter is 0, perform the access, set PREADY=1 (registered) and go to DONE.
  - DONE: the completion cycle. At its end, PREADY drops to 0. Then go to ACCESS with a fresh capture if PSEL=1, PENABLE=0 (back-to-back transfer); otherwise go to IDLE.
- Latency:
  - The access phase lasts exactly WAIT_STATES+1 cycles.
  - With WAIT_STATES=0, PREADY is high in the first PENABLE cycle. This requires the IDLE→ACCESS step to evaluate the counter==0 condition at the setup edge, registering PREADY at that edge.
- Abort: PSEL=0 while in ACCESS returns to IDLE. No write is performed and PREADY stays 0.
- Address decode:
  - word index = PADDR >> log2(DATA_WIDTH/8).
  - Error if word index >= DEPTH, or if PADDR is not aligned to the word size.
- Error response:
  - PSLVERR=1 together with PREADY.
  - Errored writes leave memory unchanged.
  - Errored reads return PRDATA=0.
- Writes:
  - Committed at the edge that sets PREADY.
  - Byte lane k is written only if PSTRB[k]=1.
  - PSTRB=0 is a legal no-op write with OKAY response.
- Reads: PRDATA is loaded from memory at the same edge. It returns to 0 when leaving DONE.
- PRDATA stays 0 on writes; PSLVERR is 0 outside DONE.
- A protocol violation (PENABLE=1 observed while in IDLE) is ignored; the slave stays in IDLE.

Optional Feature:
Macro APB_SLAVE_PROT_EN.
- Defined: adds input PPROT[2:0]. The upper half of the word space (index >= DEPTH/2) is privileged-only.
  - An access with PPROT[0]=0 to that half returns PSLVERR=1.
  - A rejected write leaves memory unchanged; a rejected read returns PRDATA=0.
- Undefined: no PPROT port; all in-range addresses are accessible.

Decomposition:
- Package apb_slave_pkg holds:
  - state encoding constants (IDLE, ACCESS, DONE);
  - OKAY/ERROR response constants;
  - a width-derived byte-offset constant function (log2 of DATA_WIDTH/8).
- One sub-module, apb_strb_ram, implements the DEPTH x DATA_WIDTH array:
  - synchronous byte-strobed write;
  - registered read;
  - synchronous clear-on-reset.
- The FSM, wait counter and decode stay in apb_mem_slave.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x04 with PSTRB=4'hF, then read 0x04 → PREADY high in the first PENABLE cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
2. WAIT_STATES=3: read → exactly 3 PENABLE cycles with PREADY=0, then 1 with PREADY=1; the completing cycle is the 4th access cycle.
3. Preload 0x11223344 at 0x08, then write 0xAABBCCDD with PSTRB=4'b0101 → readback 0x11BB33DD.
4. Access 0x40 (index 16 with DEPTH=16) or 0x02 (misaligned) → PSLVERR=1 with PREADY; a write does not alter any word; a read gives PRDATA=0.
5. Assert PRESET during the access phase of a write of 0x12345678 to 0x0C → outputs 0 immediately; readback after reset is 0x00000000.
6. Back-to-back write then read with no IDLE cycle → both complete; the read returns the just-written data. PSEL dropped mid-ACCESS → no PREADY and no write.
